// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction-memory read arbiter.
package imem_pkg;
  localparam int IMEM_ADDR_W = 7;
  localparam int IMEM_DATA_W = 32;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DBG   = 1'b1;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/imem_rsp_slot.sv
// One-deep registered response slot; the requester pops it with rsp_ready.
module imem_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              free_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  // A pop and a refill may land on the same edge, keeping full throughput.
  assign free_o = !valid_q || pop_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = err_i ? '0 : data_i;
      err_d   = err_i;
    end else if (valid_q && pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;
endmodule

// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter sharing one combinational imem read port between
// the fetch unit (requester 0) and the debug/loader path (requester 1).
module imem_rr_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = IMEM_DATA_W,
  parameter int ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  input  logic              rsp1_ready,
  output logic [ADDR_W-1:0] r_addr_imem,
  input  logic [DATA_W-1:0] r_data_imem
);
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              free0, free1, elig0, elig1, gnt0, gnt1;
  logic              mis0, mis1;

  assign elig0 = req0_valid && free0;
  assign elig1 = req1_valid && free1;

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = elig0 && (!elig1 || (last_gnt_q == REQ_DBG));
  assign gnt1 = elig1 && (!elig0 || (last_gnt_q == REQ_FETCH));

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign mis0 = (ALIGN_CHK != 0) && addr_misaligned(req0_addr[1:0]);
  assign mis1 = (ALIGN_CHK != 0) && addr_misaligned(req1_addr[1:0]);

  always_comb begin
    r_addr_imem = addr_q;
    last_gnt_d  = last_gnt_q;
    if (gnt0) begin
      r_addr_imem = req0_addr;
      last_gnt_d  = REQ_FETCH;
    end else if (gnt1) begin
      r_addr_imem = req1_addr;
      last_gnt_d  = REQ_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= REQ_DBG;
      addr_q     <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      addr_q     <= r_addr_imem;
    end
  end

  imem_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (gnt0),
    .err_i   (mis0),
    .data_i  (r_data_imem),
    .pop_i   (rsp0_ready),
    .free_o  (free0),
    .valid_o (rsp0_valid),
    .data_o  (rsp0_data),
    .err_o   (rsp0_err)
  );

  imem_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (gnt1),
    .err_i   (mis1),
    .data_i  (r_data_imem),
    .pop_i   (rsp1_ready),
    .free_o  (free1),
    .valid_o (rsp1_valid),
    .data_o  (rsp1_data),
    .err_o   (rsp1_err)
  );
endmodule

// File: tb/tb_imem_rr_arbiter.sv
// Directed bench for imem_rr_arbiter with a combinational memory model.
module tb_imem_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [6:0]  req0_addr, req1_addr, r_addr_imem;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, r_data_imem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [6:0] a);
    return 32'h5A00_0000 ^ ({25'd0, a} * 32'h0001_0101);
  endfunction

  assign r_data_imem = mem_f(r_addr_imem);

  imem_rr_arbiter #(.ADDR_W(7), .DATA_W(32), .ALIGN_CHK(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .rsp1_ready(rsp1_ready),
    .r_addr_imem(r_addr_imem), .r_data_imem(r_data_imem)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [6:0] a0, input logic v1,
                       input logic [6:0] a1, input logic r0, input logic r1);
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] s_addr [3];
    logic       c_gnt  [4];
    logic [6:0] b_addr [3];

    s_addr = '{7'h00, 7'h04, 7'h08};
    c_gnt  = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_addr = '{7'h30, 7'h34, 7'h38};

    rst_n = 1'b0;
    drive(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
    #2;
    check_eq("rst_rsp0_valid", rsp0_valid, 0);
    check_eq("rst_rsp1_valid", rsp1_valid, 0);
    check_eq("rst_rsp0_data", rsp0_data, 0);
    check_eq("rst_rsp1_err", rsp1_err, 0);
    check_eq("rst_r_addr", r_addr_imem, 0);
    #10 rst_n = 1'b1;
    tick();

    // single requester streaming
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s_addr[i], 1'b0, 7'h00, 1'b1, 1'b1);
      #1;
      check_eq("stream_req0_ready", req0_ready, 1);
      check_eq("stream_r_addr", r_addr_imem, s_addr[i]);
      tick();
      check_eq("stream_rsp0_valid", rsp0_valid, 1);
      check_eq("stream_rsp0_data", rsp0_data, mem_f(s_addr[i]));
    end

    // contention, last grant was requester 0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'h10, 1'b1, 7'h20, 1'b1, 1'b1);
      #1;
      check_eq("cont_req0_ready", req0_ready, !c_gnt[i]);
      check_eq("cont_req1_ready", req1_ready, c_gnt[i]);
      check_eq("cont_r_addr", r_addr_imem, c_gnt[i] ? 7'h20 : 7'h10);
      tick();
      if (c_gnt[i]) check_eq("cont_rsp1_data", rsp1_data, mem_f(7'h20));
      else          check_eq("cont_rsp0_data", rsp0_data, mem_f(7'h10));
    end
    drive(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
    tick();

    // backpressure on slot 1
    drive(1'b0, 7'h00, 1'b1, 7'h24, 1'b1, 1'b0);
    tick();
    check_eq("bp_fill_rsp1_valid", rsp1_valid, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b_addr[i], 1'b1, 7'h28, 1'b1, 1'b0);
      #1;
      check_eq("bp_req1_ready", req1_ready, 0);
      check_eq("bp_req0_ready", req0_ready, 1);
      check_eq("bp_r_addr", r_addr_imem, b_addr[i]);
      tick();
      check_eq("bp_rsp1_data_hold", rsp1_data, mem_f(7'h24));
      check_eq("bp_rsp1_valid_hold", rsp1_valid, 1);
      check_eq("bp_rsp0_data", rsp0_data, mem_f(b_addr[i]));
    end
    drive(1'b1, 7'h3C, 1'b1, 7'h28, 1'b1, 1'b1);
    #1;
    check_eq("bp_release_req1_ready", req1_ready, 1);
    check_eq("bp_release_req0_ready", req0_ready, 0);
    tick();
    check_eq("bp_refill_rsp1_valid", rsp1_valid, 1);
    check_eq("bp_refill_rsp1_data", rsp1_data, mem_f(7'h28));
    drive(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
    tick();

    // misaligned then aligned on requester 1
    drive(1'b0, 7'h00, 1'b1, 7'h05, 1'b1, 1'b1);
    #1;
    check_eq("mis_req1_ready", req1_ready, 1);
    tick();
    check_eq("mis_rsp1_valid", rsp1_valid, 1);
    check_eq("mis_rsp1_err", rsp1_err, 1);
    check_eq("mis_rsp1_data", rsp1_data, 0);
    drive(1'b0, 7'h00, 1'b1, 7'h0C, 1'b1, 1'b1);
    tick();
    check_eq("aligned_rsp1_err", rsp1_err, 0);
    check_eq("aligned_rsp1_data", rsp1_data, mem_f(7'h0C));

    // idle
    drive(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_r_addr", r_addr_imem, 7'h0C);
      check_eq("idle_rsp0_valid", rsp0_valid, 0);
      check_eq("idle_rsp1_valid", rsp1_valid, 0);
    end

    // fill both slots, then reset mid-cycle
    drive(1'b1, 7'h40, 1'b1, 7'h44, 1'b0, 1'b0);
    #1;
    check_eq("fill_req0_ready", req0_ready, 1);
    tick();
    tick();
    check_eq("fill_rsp0_data", rsp0_data, mem_f(7'h40));
    check_eq("fill_rsp1_data", rsp1_data, mem_f(7'h44));
    check_eq("fill_rsp1_valid", rsp1_valid, 1);
    drive(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_rsp0_valid", rsp0_valid, 0);
    check_eq("midrst_rsp1_valid", rsp1_valid, 0);
    check_eq("midrst_r_addr", r_addr_imem, 0);
    #3 rst_n = 1'b1;
    tick();
    check_eq("post_rst_rsp0_valid", rsp0_valid, 0);
    check_eq("post_rst_rsp1_valid", rsp1_valid, 0);
    drive(1'b1, 7'h10, 1'b1, 7'h20, 1'b1, 1'b1);
    #1;
    check_eq("tie_req0_ready", req0_ready, 1);
    check_eq("tie_req1_ready", req1_ready, 0);
    tick();
    check_eq("tie_rsp0_data", rsp0_data, mem_f(7'h10));
    check_eq("tie_rsp1_valid", rsp1_valid, 0);
    check_eq("tie_next_req1_ready", req1_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
